// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the packed-BCD counter family.
package bcd_pkg;

   localparam int         BCD_W    = 4;
   localparam logic [3:0] BCD_NINE = 4'd9;

   // True when every nibble in the low `digits` positions of `value` is a decimal digit.
   function automatic logic bcd_is_valid(input logic [31:0] value, input int digits);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i < digits && value[i*BCD_W +: BCD_W] > BCD_NINE) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD nibble with 0<->9 rollover and a rippling carry/borrow.
// `ld` forces the nibble to `ld_val` and takes priority over counting.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             cin,
   input  logic             ld,
   input  logic [BCD_W-1:0] ld_val,
   output logic [BCD_W-1:0] q,
   output logic             cout
);

   // Carry out when counting up from 9, borrow out when counting down from 0.
   assign cout = cin & (up ? (q == BCD_NINE) : (q == 4'd0));

   // Nibble register: forced value first, otherwise step when this digit's turn arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 4'd0;
      end else if (ld) begin
         q <= ld_val;
      end else if (en && cin) begin
         if (up) q <= (q == BCD_NINE) ? 4'd0 : q + 4'd1;
         else    q <= (q == 4'd0) ? BCD_NINE : q - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit packed-BCD up/down counter with terminal value MAX, clear,
// validated parallel load and a combinational chainable carry/borrow.
module bcd_updown_counter
   import bcd_pkg::*;
#(
   parameter int                      DIGITS = 2,
   parameter logic [4*DIGITS-1:0]     MAX    = 8'h59
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   d,
   input  logic                  ci,
   input  logic                  up,
   output logic [4*DIGITS-1:0]   q,
   output logic                  co,
   output logic                  err
);

   localparam int W = BCD_W * DIGITS;

   if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd_updown_counter: DIGITS must be 1..8");
   end

   logic [31:0]  d_ext;
   logic         d_legal;
   logic         at_term;
   logic         wrap;
   logic         force_ld;
   logic [W-1:0] force_val;
   logic [DIGITS:0] carry;
   logic         unused_carry;

   // Packed BCD orders the same as the decimal value once every nibble is <=9,
   // so the range check works on d directly.
   assign d_ext   = 32'(d);
   assign d_legal = bcd_is_valid(d_ext, DIGITS) && (d <= MAX);

   // Terminal detect: MAX when counting up, zero when counting down.
   assign at_term = up ? (q == MAX) : (q == '0);
   assign wrap    = ci & at_term;
   assign co      = wrap & ~clr & ~load;

   // The whole word is overwritten on clear, load or terminal wrap; the digit
   // ripple only handles ordinary steps.
   assign force_ld = clr | load | wrap;

   // Value forced into all digits; clear beats load beats wrap.
   always_comb begin
      force_val = '0;
      if (!clr) begin
         if (load)     force_val = d_legal ? d : '0;
         else if (!up) force_val = MAX;
      end
   end

   // Error flag tracks the legality of the most recent load; clear leaves it alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              err <= 1'b0;
      else if (!clr && load)  err <= ~d_legal;
   end

   // Digit 0 always sees an active carry-in; higher digits step when all lower ones roll.
   assign carry[0] = 1'b1;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk    (clk),
         .reset  (reset),
         .en     (ci),
         .up     (up),
         .cin    (carry[i]),
         .ld     (force_ld),
         .ld_val (force_val[i*BCD_W +: BCD_W]),
         .q      (q[i*BCD_W +: BCD_W]),
         .cout   (carry[i+1])
      );
   end

   // The top digit's ripple is superseded by the full-word terminal compare.
   assign unused_carry = carry[DIGITS];

endmodule
